// File: rtl/mccu_fsm.sv
// mccu_fsm -- multi-cycle MIPS control unit.
//
// The instruction runs through the states IF -> ID -> EXE -> MEM -> WB.
// Each instruction leaves this sequence at the first state where it is
// complete, and retire pulses in that cycle. The state is registered. The
// control outputs are decoded from the state and from op/func/z/mem_rdy.
//
// Parameters
//   MEM_HS   1: IF and MEM wait for mem_rdy.  0: memory is single-cycle.
//   ILL_TRAP 1: an undecoded instruction pulses ill in ID.
//            0: an undecoded instruction retires as a NOP.
//
// Ports
//   clk, clrn                clock; synchronous active-low reset
//   op, func, z, mem_rdy     IR fields, ALU zero flag, memory done
//   mem_req, iord            memory request and address source (0 PC, 1 ALU reg)
//   wpc, wir, wmem, wreg     write enables
//   regrt, m2reg, shift, jal, sext, alusrca, alusrcb, aluc, pcsource
//                            datapath selects (single-cycle encodings)
//   state, retire, ill       current state, completion pulse, illegal pulse
module mccu_fsm #(
    parameter int MEM_HS   = 1,
    parameter int ILL_TRAP = 1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       shift,
    output logic       jal,
    output logic       sext,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state,
    output logic       retire,
    output logic       ill
);

    localparam logic [2:0] S_IF  = 3'b000;
    localparam logic [2:0] S_ID  = 3'b001;
    localparam logic [2:0] S_EXE = 3'b010;
    localparam logic [2:0] S_MEM = 3'b011;
    localparam logic [2:0] S_WB  = 3'b100;

    logic [2:0] state_q, state_d;
    logic       mem_go_s;
    logic       i_add_s, i_sub_s, i_and_s, i_or_s, i_xor_s, i_sll_s, i_srl_s, i_sra_s, i_jr_s;
    logic       i_addi_s, i_andi_s, i_ori_s, i_xori_s, i_lw_s, i_sw_s, i_beq_s, i_bne_s;
    logic       i_lui_s, i_j_s, i_jal_s;
    logic       legal_s, is_jump_s, is_br_s, is_mem_s, is_imm_s;
    logic       dec_sext_s, dec_regrt_s, dec_shift_s;
    logic [3:0] dec_aluc_s;

    assign state = state_q;

    // When there is no handshake, every memory access is treated as done in one cycle.
    assign mem_go_s = (MEM_HS == 0) ? 1'b1 : mem_rdy;

    // Instruction decode from the IR fields.
    always_comb begin
        i_add_s  = (op == 6'b000000) && (func == 6'b100000);
        i_sub_s  = (op == 6'b000000) && (func == 6'b100010);
        i_and_s  = (op == 6'b000000) && (func == 6'b100100);
        i_or_s   = (op == 6'b000000) && (func == 6'b100101);
        i_xor_s  = (op == 6'b000000) && (func == 6'b100110);
        i_sll_s  = (op == 6'b000000) && (func == 6'b000000);
        i_srl_s  = (op == 6'b000000) && (func == 6'b000010);
        i_sra_s  = (op == 6'b000000) && (func == 6'b000011);
        i_jr_s   = (op == 6'b000000) && (func == 6'b001000);
        i_addi_s = (op == 6'b001000);
        i_andi_s = (op == 6'b001100);
        i_ori_s  = (op == 6'b001101);
        i_xori_s = (op == 6'b001110);
        i_lw_s   = (op == 6'b100011);
        i_sw_s   = (op == 6'b101011);
        i_beq_s  = (op == 6'b000100);
        i_bne_s  = (op == 6'b000101);
        i_lui_s  = (op == 6'b001111);
        i_j_s    = (op == 6'b000010);
        i_jal_s  = (op == 6'b000011);

        is_jump_s = i_j_s | i_jal_s | i_jr_s;
        is_br_s   = i_beq_s | i_bne_s;
        is_mem_s  = i_lw_s | i_sw_s;
        is_imm_s  = i_addi_s | i_andi_s | i_ori_s | i_xori_s | i_lui_s;
        legal_s   = i_add_s | i_sub_s | i_and_s | i_or_s | i_xor_s | i_sll_s | i_srl_s |
                    i_sra_s | is_jump_s | is_br_s | is_mem_s | is_imm_s;

        dec_sext_s  = i_addi_s | i_lw_s | i_sw_s | i_beq_s | i_bne_s;
        dec_regrt_s = is_imm_s | i_lw_s;
        dec_shift_s = i_sll_s | i_srl_s | i_sra_s;

        // Branches compare with a subtract, so they use the sub encoding.
        if (i_sub_s || is_br_s) begin
            dec_aluc_s = 4'b0100;
        end else if (i_and_s || i_andi_s) begin
            dec_aluc_s = 4'b0001;
        end else if (i_or_s || i_ori_s) begin
            dec_aluc_s = 4'b0101;
        end else if (i_xor_s || i_xori_s) begin
            dec_aluc_s = 4'b0010;
        end else if (i_lui_s) begin
            dec_aluc_s = 4'b0110;
        end else if (i_sll_s) begin
            dec_aluc_s = 4'b0011;
        end else if (i_srl_s) begin
            dec_aluc_s = 4'b0111;
        end else if (i_sra_s) begin
            dec_aluc_s = 4'b1111;
        end else begin
            dec_aluc_s = 4'b0000;
        end
    end

    // State register; the reset wins over every state, including a MEM wait.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Unused codes 101-111 fall back to IF.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: begin
                state_d = mem_go_s ? S_ID : S_IF;
            end
            S_ID: begin
                state_d = (is_jump_s || !legal_s) ? S_IF : S_EXE;
            end
            S_EXE: begin
                if (is_br_s) begin
                    state_d = S_IF;
                end else if (is_mem_s) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (!mem_go_s) begin
                    state_d = S_MEM;
                end else if (i_lw_s) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                state_d = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // Output decode. All outputs stay at 0 while reset is held.
    always_comb begin
        mem_req  = 1'b0;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        shift    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = 4'b0000;
        pcsource = 2'b00;
        retire   = 1'b0;
        ill      = 1'b0;
        if (!clrn) begin
            retire = 1'b0;
        end else begin
            case (state_q)
                S_IF: begin
                    // Fetch and compute PC+4 in the same cycle.
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    wir     = mem_go_s;
                    wpc     = mem_go_s;
                end
                S_ID: begin
                    // The ALU precomputes the branch target PC+4+(imm<<2).
                    alusrcb = 2'b11;
                    sext    = dec_sext_s;
                    if (i_j_s || i_jal_s) begin
                        wpc      = 1'b1;
                        pcsource = 2'b11;
                        wreg     = i_jal_s;
                        jal      = i_jal_s;
                        retire   = 1'b1;
                    end else if (i_jr_s) begin
                        wpc      = 1'b1;
                        pcsource = 2'b10;
                        retire   = 1'b1;
                    end else if (!legal_s) begin
                        ill    = (ILL_TRAP != 0);
                        retire = (ILL_TRAP == 0);
                    end else begin
                        retire = 1'b0;
                    end
                end
                S_EXE: begin
                    alusrca = 1'b1;
                    alusrcb = (is_imm_s || is_mem_s) ? 2'b10 : 2'b00;
                    aluc    = dec_aluc_s;
                    sext    = dec_sext_s;
                    shift   = dec_shift_s;
                    if (is_br_s) begin
                        pcsource = 2'b01;
                        wpc      = (i_beq_s & z) | (i_bne_s & ~z);
                        retire   = 1'b1;
                    end else begin
                        retire = 1'b0;
                    end
                end
                S_MEM: begin
                    // wmem stays high for the whole store wait.
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    wmem    = i_sw_s;
                    retire  = i_sw_s & mem_go_s;
                end
                S_WB: begin
                    wreg   = 1'b1;
                    regrt  = dec_regrt_s;
                    m2reg  = i_lw_s;
                    retire = 1'b1;
                end
                default: begin
                    retire = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mccu_fsm.sv
// Self-checking bench for mccu_fsm. There are two instances that share the
// same inputs:
//   dut_s: MEM_HS=0, ILL_TRAP=0. A vector table drives it, and the table
//          holds mem_rdy at 0 on every row, so the memory must never wait.
//   dut_h: MEM_HS=1, ILL_TRAP=1. Hand-written sequences drive it: handshake
//          waits, the illegal trap, and a reset during a store wait.
// Control word order:
//   {mem_req wpc wir wmem wreg}_{iord regrt m2reg shift jal sext alusrca}_
//   {alusrcb}_{aluc}_{pcsource}_{retire ill}
module tb_mccu_fsm;

    logic       clk = 1'b0;
    logic       clrn;
    logic [5:0] op, func;
    logic       z, mem_rdy;

    logic       mem_req_s, wpc_s, wir_s, wmem_s, wreg_s, iord_s, regrt_s, m2reg_s;
    logic       shift_s, jal_s, sext_s, alusrca_s, retire_s, ill_s;
    logic [1:0] alusrcb_s, pcsource_s;
    logic [3:0] aluc_s;
    logic [2:0] state_s;
    logic       mem_req_h, wpc_h, wir_h, wmem_h, wreg_h, iord_h, regrt_h, m2reg_h;
    logic       shift_h, jal_h, sext_h, alusrca_h, retire_h, ill_h;
    logic [1:0] alusrcb_h, pcsource_h;
    logic [3:0] aluc_h;
    logic [2:0] state_h;

    always #5 clk = ~clk;

    mccu_fsm #(.MEM_HS(0), .ILL_TRAP(0)) dut_s (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .mem_req(mem_req_s), .wpc(wpc_s), .wir(wir_s), .wmem(wmem_s), .wreg(wreg_s),
        .iord(iord_s), .regrt(regrt_s), .m2reg(m2reg_s), .shift(shift_s), .jal(jal_s),
        .sext(sext_s), .alusrca(alusrca_s), .alusrcb(alusrcb_s), .aluc(aluc_s),
        .pcsource(pcsource_s), .state(state_s), .retire(retire_s), .ill(ill_s)
    );

    mccu_fsm #(.MEM_HS(1), .ILL_TRAP(1)) dut_h (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .mem_req(mem_req_h), .wpc(wpc_h), .wir(wir_h), .wmem(wmem_h), .wreg(wreg_h),
        .iord(iord_h), .regrt(regrt_h), .m2reg(m2reg_h), .shift(shift_h), .jal(jal_h),
        .sext(sext_h), .alusrca(alusrca_h), .alusrcb(alusrcb_h), .aluc(aluc_h),
        .pcsource(pcsource_h), .state(state_h), .retire(retire_h), .ill(ill_h)
    );

    logic [21:0] ctl_s, ctl_h;
    assign ctl_s = {mem_req_s, wpc_s, wir_s, wmem_s, wreg_s, iord_s, regrt_s, m2reg_s, shift_s,
                    jal_s, sext_s, alusrca_s, alusrcb_s, aluc_s, pcsource_s, retire_s, ill_s};
    assign ctl_h = {mem_req_h, wpc_h, wir_h, wmem_h, wreg_h, iord_h, regrt_h, m2reg_h, shift_h,
                    jal_h, sext_h, alusrca_h, alusrcb_h, aluc_h, pcsource_h, retire_h, ill_h};

    // Hand-derived expected control words.
    localparam logic [21:0] C_RST      = 22'b00000_0000000_00_0000_00_00;
    localparam logic [21:0] C_IF       = 22'b11100_0000000_01_0000_00_00;
    localparam logic [21:0] C_IF_WAIT  = 22'b10000_0000000_01_0000_00_00;
    localparam logic [21:0] C_ID       = 22'b00000_0000000_11_0000_00_00;
    localparam logic [21:0] C_ID_SX    = 22'b00000_0000010_11_0000_00_00;
    localparam logic [21:0] C_ID_JAL   = 22'b01001_0000100_11_0000_11_10;
    localparam logic [21:0] C_ID_J     = 22'b01000_0000000_11_0000_11_10;
    localparam logic [21:0] C_ID_JR    = 22'b01000_0000000_11_0000_10_10;
    localparam logic [21:0] C_ID_NOP   = 22'b00000_0000000_11_0000_00_10;
    localparam logic [21:0] C_ID_ILL   = 22'b00000_0000000_11_0000_00_01;
    localparam logic [21:0] C_EX_ADD   = 22'b00000_0000001_00_0000_00_00;
    localparam logic [21:0] C_EX_BR_T  = 22'b01000_0000011_00_0100_01_10;
    localparam logic [21:0] C_EX_BR_N  = 22'b00000_0000011_00_0100_01_10;
    localparam logic [21:0] C_EX_MEM   = 22'b00000_0000011_10_0000_00_00;
    localparam logic [21:0] C_EX_SLL   = 22'b00000_0001001_00_0011_00_00;
    localparam logic [21:0] C_EX_LUI   = 22'b00000_0000001_10_0110_00_00;
    localparam logic [21:0] C_MEM_LW   = 22'b10000_1000000_00_0000_00_00;
    localparam logic [21:0] C_MEM_SW   = 22'b10010_1000000_00_0000_00_00;
    localparam logic [21:0] C_MEM_SWGO = 22'b10010_1000000_00_0000_00_10;
    localparam logic [21:0] C_WB       = 22'b00001_0000000_00_0000_00_10;
    localparam logic [21:0] C_WB_LW    = 22'b00001_0110000_00_0000_00_10;
    localparam logic [21:0] C_WB_I     = 22'b00001_0100000_00_0000_00_10;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011, OP_LUI = 6'b001111, OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000, F_JR = 6'b001000;

    typedef struct {
        string       name;
        logic        clrn;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [21:0] ctl;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic addv(input string nm, input logic c, input logic [5:0] o, input logic [5:0] f,
                        input logic zz, input logic [2:0] es, input logic [21:0] ec);
        vec_t v;
        v.name = nm; v.clrn = c; v.op = o; v.func = f; v.z = zz; v.rdy = 1'b0;
        v.st = es; v.ctl = ec;
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs after the falling edge, then compare the selected instance.
    task automatic step(input string nm, input logic sel_h, input logic c, input logic [5:0] o,
                        input logic [5:0] f, input logic zz, input logic rr,
                        input logic [2:0] es, input logic [21:0] ec);
        logic [2:0]  a_st;
        logic [21:0] a_ctl;
        @(negedge clk);
        clrn = c; op = o; func = f; z = zz; mem_rdy = rr;
        #1;
        a_st  = sel_h ? state_h : state_s;
        a_ctl = sel_h ? ctl_h : ctl_s;
        n_chk++;
        if (a_st !== es) begin
            n_fail++;
            $display("FAIL %s state: got %b expected %b", nm, a_st, es);
        end
        n_chk++;
        if (a_ctl !== ec) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", nm, a_ctl, ec);
        end
    endtask

    initial begin
        clrn = 1'b0; op = 6'b000000; func = 6'b000000; z = 1'b0; mem_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // Table for dut_s: each row is one cycle, and each sequence ends with the instruction's retire.
        addv("rst",      1'b0, OP_R,   F_ADD, 1'b0, 3'd0, C_RST);
        addv("add_if",   1'b1, OP_R,   F_ADD, 1'b0, 3'd0, C_IF);
        addv("add_id",   1'b1, OP_R,   F_ADD, 1'b0, 3'd1, C_ID);
        addv("add_ex",   1'b1, OP_R,   F_ADD, 1'b0, 3'd2, C_EX_ADD);
        addv("add_wb",   1'b1, OP_R,   F_ADD, 1'b0, 3'd4, C_WB);
        addv("lw_if",    1'b1, OP_LW,  F_ADD, 1'b0, 3'd0, C_IF);
        addv("lw_id",    1'b1, OP_LW,  F_ADD, 1'b0, 3'd1, C_ID_SX);
        addv("lw_ex",    1'b1, OP_LW,  F_ADD, 1'b0, 3'd2, C_EX_MEM);
        addv("lw_mem",   1'b1, OP_LW,  F_ADD, 1'b0, 3'd3, C_MEM_LW);
        addv("lw_wb",    1'b1, OP_LW,  F_ADD, 1'b0, 3'd4, C_WB_LW);
        addv("sw_if",    1'b1, OP_SW,  F_ADD, 1'b0, 3'd0, C_IF);
        addv("sw_id",    1'b1, OP_SW,  F_ADD, 1'b0, 3'd1, C_ID_SX);
        addv("sw_ex",    1'b1, OP_SW,  F_ADD, 1'b0, 3'd2, C_EX_MEM);
        addv("sw_mem",   1'b1, OP_SW,  F_ADD, 1'b0, 3'd3, C_MEM_SWGO);
        addv("beqt_if",  1'b1, OP_BEQ, F_ADD, 1'b0, 3'd0, C_IF);
        addv("beqt_id",  1'b1, OP_BEQ, F_ADD, 1'b0, 3'd1, C_ID_SX);
        addv("beqt_ex",  1'b1, OP_BEQ, F_ADD, 1'b1, 3'd2, C_EX_BR_T);
        addv("beqn_if",  1'b1, OP_BEQ, F_ADD, 1'b0, 3'd0, C_IF);
        addv("beqn_id",  1'b1, OP_BEQ, F_ADD, 1'b0, 3'd1, C_ID_SX);
        addv("beqn_ex",  1'b1, OP_BEQ, F_ADD, 1'b0, 3'd2, C_EX_BR_N);
        addv("bnet_if",  1'b1, OP_BNE, F_ADD, 1'b0, 3'd0, C_IF);
        addv("bnet_id",  1'b1, OP_BNE, F_ADD, 1'b0, 3'd1, C_ID_SX);
        addv("bnet_ex",  1'b1, OP_BNE, F_ADD, 1'b0, 3'd2, C_EX_BR_T);
        addv("jal_if",   1'b1, OP_JAL, F_ADD, 1'b0, 3'd0, C_IF);
        addv("jal_id",   1'b1, OP_JAL, F_ADD, 1'b0, 3'd1, C_ID_JAL);
        addv("j_if",     1'b1, OP_J,   F_ADD, 1'b0, 3'd0, C_IF);
        addv("j_id",     1'b1, OP_J,   F_ADD, 1'b0, 3'd1, C_ID_J);
        addv("jr_if",    1'b1, OP_R,   F_JR,  1'b0, 3'd0, C_IF);
        addv("jr_id",    1'b1, OP_R,   F_JR,  1'b0, 3'd1, C_ID_JR);
        addv("sll_if",   1'b1, OP_R,   F_SLL, 1'b0, 3'd0, C_IF);
        addv("sll_id",   1'b1, OP_R,   F_SLL, 1'b0, 3'd1, C_ID);
        addv("sll_ex",   1'b1, OP_R,   F_SLL, 1'b0, 3'd2, C_EX_SLL);
        addv("sll_wb",   1'b1, OP_R,   F_SLL, 1'b0, 3'd4, C_WB);
        addv("lui_if",   1'b1, OP_LUI, F_ADD, 1'b0, 3'd0, C_IF);
        addv("lui_id",   1'b1, OP_LUI, F_ADD, 1'b0, 3'd1, C_ID);
        addv("lui_ex",   1'b1, OP_LUI, F_ADD, 1'b0, 3'd2, C_EX_LUI);
        addv("lui_wb",   1'b1, OP_LUI, F_ADD, 1'b0, 3'd4, C_WB_I);
        addv("nop_if",   1'b1, OP_BAD, F_ADD, 1'b0, 3'd0, C_IF);
        addv("nop_id",   1'b1, OP_BAD, F_ADD, 1'b0, 3'd1, C_ID_NOP);
        addv("back_if",  1'b1, OP_R,   F_ADD, 1'b0, 3'd0, C_IF);

        foreach (vq[i]) begin
            step(vq[i].name, 1'b0, vq[i].clrn, vq[i].op, vq[i].func, vq[i].z, vq[i].rdy,
                 vq[i].st, vq[i].ctl);
        end

        // lw with handshake: IF waits 3 cycles, MEM waits 2; mem_rdy is also high in EXE, where it must be ignored.
        step("A_rst",   1'b1, 1'b0, OP_LW, F_ADD, 1'b0, 1'b0, 3'd0, C_RST);
        step("A_ifw1",  1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd0, C_IF_WAIT);
        step("A_ifw2",  1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd0, C_IF_WAIT);
        step("A_ifw3",  1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd0, C_IF_WAIT);
        step("A_if",    1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b1, 3'd0, C_IF);
        step("A_id",    1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd1, C_ID_SX);
        step("A_ex",    1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b1, 3'd2, C_EX_MEM);
        step("A_memw1", 1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd3, C_MEM_LW);
        step("A_memw2", 1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd3, C_MEM_LW);
        step("A_mem",   1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b1, 3'd3, C_MEM_LW);
        step("A_wb",    1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd4, C_WB_LW);
        step("A_next",  1'b1, 1'b1, OP_LW, F_ADD, 1'b0, 1'b0, 3'd0, C_IF_WAIT);

        // Illegal opcode trap: ill pulses in ID, with no enables and no retire.
        step("B_if",    1'b1, 1'b1, OP_BAD, F_ADD, 1'b0, 1'b1, 3'd0, C_IF);
        step("B_id",    1'b1, 1'b1, OP_BAD, F_ADD, 1'b0, 1'b0, 3'd1, C_ID_ILL);
        step("B_next",  1'b1, 1'b1, OP_BAD, F_ADD, 1'b0, 1'b0, 3'd0, C_IF_WAIT);

        // jal with handshake.
        step("D_if",    1'b1, 1'b1, OP_JAL, F_ADD, 1'b0, 1'b1, 3'd0, C_IF);
        step("D_id",    1'b1, 1'b1, OP_JAL, F_ADD, 1'b0, 1'b0, 3'd1, C_ID_JAL);
        step("D_next",  1'b1, 1'b1, OP_JAL, F_ADD, 1'b0, 1'b0, 3'd0, C_IF_WAIT);

        // Store waiting in MEM, then reset: wmem drops at once and the FSM lands in IF.
        step("C_if",    1'b1, 1'b1, OP_SW, F_ADD, 1'b0, 1'b1, 3'd0, C_IF);
        step("C_id",    1'b1, 1'b1, OP_SW, F_ADD, 1'b0, 1'b0, 3'd1, C_ID_SX);
        step("C_ex",    1'b1, 1'b1, OP_SW, F_ADD, 1'b0, 1'b0, 3'd2, C_EX_MEM);
        step("C_memw1", 1'b1, 1'b1, OP_SW, F_ADD, 1'b0, 1'b0, 3'd3, C_MEM_SW);
        step("C_memw2", 1'b1, 1'b1, OP_SW, F_ADD, 1'b0, 1'b0, 3'd3, C_MEM_SW);
        step("C_rst",   1'b1, 1'b0, OP_SW, F_ADD, 1'b0, 1'b0, 3'd3, C_RST);
        step("C_after", 1'b1, 1'b1, OP_SW, F_ADD, 1'b0, 1'b0, 3'd0, C_IF_WAIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
